adc_frame_packer: RTL and testbench
===================================

Name: adc_frame_packer

Overview:
- Upstream neighbour of the AXI4-Lite control/status register block in the Zynq ADC glue.
- Takes the raw ADC sample stream, aligns it to the ADC sync marker and cuts it into fixed-length frames.
- Buffers frames in an internal FIFO and emits them on an AXI4-Stream master towards the DMA.
- Produces the frame_counter, overflow_counter, err_conds and sync_reg status words that the register block reads, and consumes that block's pl_enable, pl_resetn and control[2] (mock mode).

Parameters:
- DATA_W, 32: ADC sample width; equals the tdata width.
- FRAME_LEN, 256: samples per frame; must be 2..FIFO_DEPTH.
- FIFO_DEPTH, 1024: FIFO words; power of two, at least FRAME_LEN.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous active-low reset.
- pl_enable  in  1  capture enable from the register block.
- pl_resetn  in  1  synchronous active-low soft reset from the register block.
- mock_mode  in  1  control[2]; selects the test pattern (see Optional Feature).
- adc_valid  in  1  sample strobe; there is no backpressure towards the ADC.
- adc_data  in  DATA_W  sample value.
- adc_sync  in  1  frame-start marker; qualified by adc_valid.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the last word of each frame.
- frame_counter  out  32  number of frames fully written into the FIFO.
- overflow_counter  out  32  number of frames dropped.
- err_conds  out  32  one-cycle error pulses; the register block ORs them into a sticky register.
- sync_reg  out  32  sync diagnostics.

Behaviour:
- Reset: resetn low sets all outputs and counters to 0, empties the FIFO and puts the FSM in IDLE. pl_resetn low has the same effect, synchronously.
- FSM states:
  - IDLE: leave when pl_enable=1, go to WAIT_SYNC.
  - WAIT_SYNC: discard samples until adc_valid&&adc_sync. That sample is index 0 and goes through the admission check.
  - CAPTURE: write each valid sample to the FIFO.
  - DROP: discard samples.
- Sample index: counts 0..FRAME_LEN-1 over valid samples. After index FRAME_LEN-1:
  - go to IDLE if pl_enable=0;
  - otherwise the next valid sample is the next frame's index 0 (no new sync required).
- Admission check at index 0: if free words (FIFO_DEPTH minus occupancy) are at least FRAME_LEN, go to CAPTURE. Otherwise go to DROP for the whole frame.
- Overflow event: at the DROP admission, overflow_counter increments by 1 and err_conds[0] pulses. An admitted frame never overflows mid-frame.
- pl_enable falling mid-frame: the current CAPTURE or DROP frame runs to completion, then IDLE. No partial frames are ever emitted.
- Frame completion: frame_counter increments on the same edge the index FRAME_LEN-1 word is written. The tlast flag is stored alongside that word in the FIFO.
- Counters wrap modulo 2^32.
- Stray sync: adc_sync on a valid sample with index≠0 in CAPTURE/DROP pulses err_conds[1]. It is otherwise ignored; framing continues.
- sync_reg[15:0]: index of the most recent sync-qualified sample.
- sync_reg[31:16]: count of stray syncs, saturating at 0xFFFF.
- err_conds[2] pulses when adc_valid arrives while IDLE with pl_enable=1 (sample lost during start-up).
- err_conds[31:3] are always 0.
- FIFO:
  - writes occur one cycle after the adc_valid sample;
  - output is a registered first-word-fall-through;
  - a word written at edge k is on m_axis with tvalid=1 after edge k+1;
  - sustains 1 word/cycle in and out simultaneously;
  - tdata and tlast are held stable while tvalid&&!tready.
- Simultaneous FIFO read and write at full or empty: occupancy stays consistent. Pointers wrap at FIFO_DEPTH.

Optional Feature:
- Macro: ADC_MOCK_DATA_EN.
- When defined and mock_mode=1, each written word is replaced by a 32-bit pattern counter. The counter starts at 0 after reset/pl_resetn and increments per written word, not per dropped sample. Framing, sync and tlast behaviour are unchanged.
- When the macro is undefined, mock_mode is ignored and adc_data is always used.

Test Plan:
1. Enable, then feed 2 frames with sync on sample 0, FRAME_LEN=8, tready=1 → 16 words, data equal to input, tlast on words 8 and 16, frame_counter=2, overflow_counter=0.
2. FIFO_DEPTH=16, FRAME_LEN=8, tready=0, 3 frames → frames 1–2 stored, frame 3 dropped, overflow_counter=1, one err_conds[0] pulse. Then raise tready → exactly 16 words out.
3. Sync asserted on index 3 mid-frame → one err_conds[1] pulse, sync_reg=0x0001_0003, frame boundaries unchanged.
4. Drop pl_enable at index 4 → frame completes with tlast on index 7, then IDLE. Further samples are not written.
5. Assert resetn low asynchronously mid-frame with 5 words buffered → tvalid=0 and all counters 0 immediately. After release, WAIT_SYNC is required before capture resumes.
6. With ADC_MOCK_DATA_EN defined and mock_mode=1, 2 frames → tdata 0..15 regardless of adc_data.

Source files
------------

// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: AXI4-Stream bundle carrying packed ADC frames.
// master drives data/valid/last, slave drives ready.
interface adc_frame_packer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: sync-aligned ADC framer, frame FIFO and AXIS master.
// Optional ADC_MOCK_DATA_EN swaps written words for a pattern counter.
module adc_frame_packer #(
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pl_enable,
  input  logic               pl_resetn,
  input  logic               mock_mode,
  input  logic               adc_valid,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_sync,
  adc_frame_packer_if.master m_axis,
  output logic [31:0]        frame_counter,
  output logic [31:0]        overflow_counter,
  output logic [31:0]        err_conds,
  output logic [31:0]        sync_reg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = AW + 2;
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ADMIT_MAX = CW'(FIFO_DEPTH - FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DROP} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic              take, head, last, admit;
  logic              wr, ovf, stray, lost;
  logic [DATA_W-1:0] wdata;
  logic              wr_q;
  word_t             wword_q;
  logic              ovf_q, stray_q, lost_q;
  logic [15:0]       sync_idx, stray_cnt;
  word_t             mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     mem_cnt, occ;
  logic              rd_mem;
  word_t             out_q;
  logic              out_vld;

  // Pending pipeline write counts as occupied so admission never over-commits.
  assign occ   = mem_cnt + CW'(out_vld) + CW'(wr_q);
  assign admit = (occ <= ADMIT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else if (!pl_resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take)
        idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pl_enable) state_d = S_WAIT;
      default: begin
        if (take) begin
          if (head) state_d = admit ? S_CAP : S_DROP;
          if (last && !pl_enable) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    take = 1'b0;
    unique case (state_q)
      S_WAIT:        take = adc_valid && adc_sync;
      S_CAP, S_DROP: take = adc_valid;
      default:       take = 1'b0;
    endcase
    head  = take && (idx_q == '0);
    last  = take && (idx_q == LAST_IDX);
    wr    = take && (head ? admit : (state_q == S_CAP));
    ovf   = head && !admit;
    stray = take && adc_sync && !head;
    lost  = (state_q == S_IDLE) && pl_enable && adc_valid;
  end

`ifdef ADC_MOCK_DATA_EN
  logic [31:0] mock_cnt;

  assign wdata = mock_mode ? DATA_W'(mock_cnt) : adc_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      mock_cnt <= '0;
    else if (!pl_resetn)
      mock_cnt <= '0;
    else if (wr)
      mock_cnt <= mock_cnt + 32'd1;
  end
`else
  logic unused_mock;

  assign unused_mock = mock_mode;
  assign wdata       = adc_data;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q             <= 1'b0;
      wword_q          <= '0;
      ovf_q            <= 1'b0;
      stray_q          <= 1'b0;
      lost_q           <= 1'b0;
      frame_counter    <= '0;
      overflow_counter <= '0;
      sync_idx         <= '0;
      stray_cnt        <= '0;
    end else if (!pl_resetn) begin
      wr_q             <= 1'b0;
      wword_q          <= '0;
      ovf_q            <= 1'b0;
      stray_q          <= 1'b0;
      lost_q           <= 1'b0;
      frame_counter    <= '0;
      overflow_counter <= '0;
      sync_idx         <= '0;
      stray_cnt        <= '0;
    end else begin
      wr_q         <= wr;
      wword_q.last <= last;
      wword_q.data <= wdata;
      ovf_q        <= ovf;
      stray_q      <= stray;
      lost_q       <= lost;
      if (ovf)
        overflow_counter <= overflow_counter + 32'd1;
      if (wr_q && wword_q.last)
        frame_counter <= frame_counter + 32'd1;
      if (take && adc_sync)
        sync_idx <= 16'(idx_q);
      if (stray && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;
    end
  end

  assign err_conds = {29'd0, lost_q, stray_q, ovf_q};
  assign sync_reg  = {stray_cnt, sync_idx};

  assign rd_mem = (mem_cnt != '0) && (!out_vld || m_axis.tready);

  always_ff @(posedge clk) begin
    if (wr_q)
      mem[wptr] <= wword_q;
  end

  // Output register is the FWFT head; it refills whenever it empties or drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (!pl_resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      if (wr_q)
        wptr <= wptr + 1'b1;
      if (rd_mem) begin
        rptr  <= rptr + 1'b1;
        out_q <= mem[rptr];
      end
      out_vld <= rd_mem || (out_vld && !m_axis.tready);
      mem_cnt <= mem_cnt + CW'(wr_q) - CW'(rd_mem);
    end
  end

  assign m_axis.tdata  = out_q.data;
  assign m_axis.tlast  = out_q.last;
  assign m_axis.tvalid = out_vld;
endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed checks of framing, overflow, sync, reset.
// FRAME_LEN=8, FIFO_DEPTH=16; define ADC_MOCK_DATA_EN to cover mock data.
module tb_adc_frame_packer;
  localparam int DW = 32;
  localparam int FL = 8;
  localparam int FD = 16;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        pl_enable = 1'b0;
  logic        pl_resetn = 1'b1;
  logic        mock_mode = 1'b0;
  logic        adc_valid = 1'b0;
  logic        adc_sync  = 1'b0;
  logic [31:0] adc_data  = '0;
  logic [31:0] frame_counter, overflow_counter, err_conds, sync_reg;

  adc_frame_packer_if #(.DATA_W(DW)) axis ();

  adc_frame_packer #(
    .DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .pl_enable(pl_enable),
    .pl_resetn(pl_resetn),
    .mock_mode(mock_mode),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .adc_sync(adc_sync),
    .m_axis(axis),
    .frame_counter(frame_counter),
    .overflow_counter(overflow_counter),
    .err_conds(err_conds),
    .sync_reg(sync_reg)
  );

  always #5 clk = ~clk;

  logic [32:0] q[$];
  int e0 = 0, e1 = 0, e2 = 0, ehi = 0;
  int total = 0, bad = 0;
  int base, eb;

  always @(negedge clk) begin
    if (axis.tvalid && axis.tready)
      q.push_back({axis.tlast, axis.tdata});
    if (err_conds[0]) e0++;
    if (err_conds[1]) e1++;
    if (err_conds[2]) e2++;
    if (err_conds[31:3] != 29'd0) ehi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [31:0] d, input logic s);
    adc_valid = 1'b1;
    adc_data  = d;
    adc_sync  = s;
    tick();
    adc_valid = 1'b0;
    adc_sync  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 200 && q.size() < n; k++) tick();
    repeat (4) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", 64'(axis.tvalid), 0);
    chk("rst_frames", frame_counter, 0);
    chk("rst_ovf", overflow_counter, 0);
    chk("rst_err", err_conds, 0);
    chk("rst_sync", sync_reg, 0);
    resetn = 1'b1;
    tick();

    // two back-to-back frames, free-running sink
    pl_enable = 1'b1;
    repeat (2) tick();
    base = q.size();
    for (int i = 0; i < 16; i++) smp(32'h100 + 32'(i), (i % 8) == 0);
    drain(base + 16);
    chk("t1_count", 64'(q.size() - base), 16);
    for (int i = 0; i < 16; i++)
      chk("t1_word", 64'(q[base + i]), {31'd0, (i % 8) == 7, 32'h100 + 32'(i)});
    chk("t1_frames", frame_counter, 2);
    chk("t1_ovf", overflow_counter, 0);
    chk("t1_e0", 64'(e0), 0);

    // stalled sink: third frame must be dropped
    axis.tready = 1'b0;
    base = q.size();
    eb = e0;
    for (int i = 0; i < 24; i++) smp(32'h200 + 32'(i), (i % 8) == 0);
    repeat (3) tick();
    chk("t2_tvalid", 64'(axis.tvalid), 1);
    chk("t2_hold_a", axis.tdata, 32'h200);
    repeat (3) tick();
    chk("t2_hold_b", axis.tdata, 32'h200);
    chk("t2_hold_last", 64'(axis.tlast), 0);
    chk("t2_ovf", overflow_counter, 1);
    chk("t2_e0", 64'(e0 - eb), 1);
    chk("t2_frames", frame_counter, 4);
    axis.tready = 1'b1;
    repeat (40) tick();
    chk("t2_count", 64'(q.size() - base), 16);
    chk("t2_w7", 64'(q[base + 7]), {31'd0, 1'b1, 32'h207});
    chk("t2_w8", 64'(q[base + 8]), {31'd0, 1'b0, 32'h208});
    chk("t2_w15", 64'(q[base + 15]), {31'd0, 1'b1, 32'h20F});

    // soft reset, then stray sync at index 3
    pl_resetn = 1'b0;
    tick();
    pl_resetn = 1'b1;
    chk("t3_soft_frames", frame_counter, 0);
    chk("t3_soft_ovf", overflow_counter, 0);
    repeat (2) tick();
    base = q.size();
    eb = e1;
    for (int i = 0; i < 16; i++) smp(32'h300 + 32'(i), i == 0 || i == 3);
    drain(base + 16);
    chk("t3_count", 64'(q.size() - base), 16);
    chk("t3_w3", 64'(q[base + 3]), {31'd0, 1'b0, 32'h303});
    chk("t3_w7", 64'(q[base + 7]), {31'd0, 1'b1, 32'h307});
    chk("t3_w8", 64'(q[base + 8]), {31'd0, 1'b0, 32'h308});
    chk("t3_w15", 64'(q[base + 15]), {31'd0, 1'b1, 32'h30F});
    chk("t3_e1", 64'(e1 - eb), 1);
    chk("t3_sync", sync_reg, 32'h0001_0003);
    chk("t3_frames", frame_counter, 2);

    // enable drops at index 4: frame finishes, then idle
    base = q.size();
    eb = e2;
    for (int i = 0; i < 4; i++) smp(32'h400 + 32'(i), i == 0);
    pl_enable = 1'b0;
    for (int i = 4; i < 8; i++) smp(32'h400 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) smp(32'h4F0 + 32'(i), 1'b0);
    drain(base + 8);
    chk("t4_count", 64'(q.size() - base), 8);
    chk("t4_w7", 64'(q[base + 7]), {31'd0, 1'b1, 32'h407});
    chk("t4_frames", frame_counter, 3);
    chk("t4_e2_none", 64'(e2 - eb), 0);
    pl_enable = 1'b1;
    smp(32'h500, 1'b0);
    repeat (3) tick();
    chk("t4_e2_lost", 64'(e2 - eb), 1);
    chk("t4_no_write", 64'(q.size() - base), 8);

    // async reset with 5 words buffered
    axis.tready = 1'b0;
    for (int i = 0; i < 5; i++) smp(32'h600 + 32'(i), i == 0);
    repeat (3) tick();
    chk("t5_pre_tvalid", 64'(axis.tvalid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_tvalid", 64'(axis.tvalid), 0);
    chk("t5_frames", frame_counter, 0);
    chk("t5_ovf", overflow_counter, 0);
    chk("t5_sync", sync_reg, 0);
    tick();
    resetn = 1'b1;
    axis.tready = 1'b1;
    repeat (2) tick();
    base = q.size();
    for (int i = 0; i < 8; i++) smp(32'h700 + 32'(i), 1'b0);
    repeat (5) tick();
    chk("t5_nosync", 64'(q.size() - base), 0);
    for (int i = 0; i < 8; i++) smp(32'h800 + 32'(i), i == 0);
    drain(base + 8);
    chk("t5_count", 64'(q.size() - base), 8);
    chk("t5_w0", 64'(q[base]), {31'd0, 1'b0, 32'h800});
    chk("t5_w7", 64'(q[base + 7]), {31'd0, 1'b1, 32'h807});
    chk("t5_frames2", frame_counter, 1);

    // mock pattern (or plain data when the feature is compiled out)
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    mock_mode = 1'b1;
    repeat (2) tick();
    base = q.size();
    for (int i = 0; i < 16; i++) smp(32'hDEAD_0000 + 32'(i), (i % 8) == 0);
    drain(base + 16);
    chk("t6_count", 64'(q.size() - base), 16);
    for (int i = 0; i < 16; i++) begin
`ifdef ADC_MOCK_DATA_EN
      chk("t6_mock", 64'(q[base + i]), {31'd0, (i % 8) == 7, 32'(i)});
`else
      chk("t6_raw", 64'(q[base + i]),
          {31'd0, (i % 8) == 7, 32'hDEAD_0000 + 32'(i)});
`endif
    end
    chk("t6_frames", frame_counter, 2);
    chk("err_hi", 64'(ehi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
